pixel_sink: RTL

- Receiving end of the plot interface: accepts x/y/colour/plot pixel requests from shape-drawing datapaths and turns them into ordered framebuffer writes for the 160x120 display.
- Buffers requests in a small FIFO and stalls when the framebuffer port is not granted.
- Discards off-screen coordinates and provides a full-screen clear sweep.

---
 rtl/pixel_sink.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/pixel_sink.sv
`default_nettype none
// ============================================================================
// Module   : pixel_sink
// Purpose  : Buffers plot requests and turns them into ordered framebuffer writes,
//            discarding off-screen pixels and offering a full-screen clear sweep.
// Revision : 1.0
// ============================================================================
module pixel_sink #(
    parameter int         FIFO_DEPTH   = 4,
    parameter int         XMAX         = 160,
    parameter int         YMAX         = 120,
    parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        plot_valid,
    output logic        plot_ready,
    input  logic [7:0]  x,
    input  logic [6:0]  y,
    input  logic [2:0]  colour,
    input  logic        clear_req,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [14:0] mem_addr,
    output logic [2:0]  mem_data,
    output logic        busy,
    output logic        clear_done,
    output logic [7:0]  drop_count
);
    localparam int              AW        = $clog2(FIFO_DEPTH);
    localparam int              CW        = AW + 1;
    localparam logic [CW-1:0]   FULL_CNT  = CW'(FIFO_DEPTH);
    localparam logic [8:0]      X_LIM     = 9'(XMAX);
    localparam logic [7:0]      Y_LIM     = 8'(YMAX);
    localparam logic [14:0]     X_MUL     = 15'(XMAX);
    localparam logic [14:0]     LAST_ADDR = 15'(XMAX * YMAX - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_CLEAR = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [7:0] px;
        logic [6:0] py;
        logic [2:0] pc;
    } pix_t;

    state_t          state_q, state_d;
    pix_t            fifo_q [FIFO_DEPTH];
    pix_t            fifo_d [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [14:0]     sweep_q, sweep_d, addr_q, addr_d;
    logic [2:0]      data_q, data_d;
    logic            we_q, we_d, done_q, done_d, live_q;
    logic [7:0]      drops_q, drops_d;

    logic            fifo_full, fifo_empty, accept, on_screen, push, pop;
    pix_t            head;
    logic [14:0]     head_addr;

    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);
    // live_q keeps plot_ready low until the first edge after reset release
    assign plot_ready = live_q && (state_q == S_IDLE) && !fifo_full;
    assign accept     = plot_valid && plot_ready;
    assign on_screen  = ({1'b0, x} < X_LIM) && ({1'b0, y} < Y_LIM);
    assign push       = accept && on_screen;
    assign pop        = !fifo_empty && mem_ready && ((state_q == S_IDLE) || (state_q == S_DRAIN));
    assign head       = fifo_q[rd_ptr_q];
    assign head_addr  = 15'(head.py) * X_MUL + 15'(head.px);

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drops_d  = drops_q;
        state_d  = state_q;
        sweep_d  = sweep_q;
        addr_d   = addr_q;
        data_d   = data_q;
        we_d     = 1'b0;
        done_d   = 1'b0;

        if (push) begin
            fifo_d[wr_ptr_q] = '{px: x, py: y, pc: colour};
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            we_d     = 1'b1;
            addr_d   = head_addr;
            data_d   = head.pc;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (accept && !on_screen && (drops_q != 8'hFF))
            drops_d = drops_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (clear_req)
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // empty FIFO here also means no write was issued this edge
                if (fifo_empty) begin
                    state_d = S_CLEAR;
                    sweep_d = '0;
                end
            end
            S_CLEAR: begin
                if (mem_ready) begin
                    we_d    = 1'b1;
                    addr_d  = sweep_q;
                    data_d  = CLEAR_COLOUR;
                    sweep_d = sweep_q + 1'b1;
                    if (sweep_q == LAST_ADDR) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            for (int i = 0; i < FIFO_DEPTH; i++)
                fifo_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            sweep_q  <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
            drops_q  <= '0;
            live_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            sweep_q  <= sweep_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            we_q     <= we_d;
            done_q   <= done_d;
            drops_q  <= drops_d;
            live_q   <= 1'b1;
        end
    end

    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_data   = data_q;
    assign clear_done = done_q;
    assign drop_count = drops_q;
    assign busy       = (state_q != S_IDLE) || !fifo_empty || we_q;

endmodule
`default_nettype wire
